// File: rtl/jc_pkg.sv
// Shared types and helpers for the Johnson-code receive path.
// Widths up to JC_MAX_W are supported by the helper functions.
package jc_pkg;

  localparam int JC_MAX_W = 32;

  typedef enum logic {
    JC_SEARCH,
    JC_LOCKED
  } jc_state_e;

  function automatic int jc_iw(input int w);
    return $clog2(2 * w);
  endfunction

  // Legal Johnson codes have at most one bit transition along the bus.
  function automatic logic jc_legal(
    input logic [0:JC_MAX_W-1] code,
    input int                  w
  );
    int t;
    t = 0;
    for (int i = 1; i < JC_MAX_W; i++) begin
      if (i < w && code[i] != code[i-1]) t++;
    end
    return (t <= 1);
  endfunction

  function automatic logic [7:0] jc_to_idx(
    input logic [0:JC_MAX_W-1] code,
    input int                  w
  );
    int ones;
    int n;
    ones = 0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i < w && code[i]) ones++;
    end
    if (code[0]) n = ones;
    else n = (w + (w - ones)) % (2 * w);
    return 8'(n);
  endfunction

endpackage

// File: rtl/johnson_code_chk.sv
// Combinational legality check and phase decode of one Johnson code.
module johnson_code_chk
  import jc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW    = 4
) (
  input  logic [0:WIDTH-1] jc_in,
  output logic             legal,
  output logic [IW-1:0]    idx
);

  logic [0:JC_MAX_W-1] code;
  logic [7:0]          full;

  always_comb begin
    code            = '0;
    code[0:WIDTH-1] = jc_in;
    full            = jc_to_idx(code, WIDTH);
    idx             = full[IW-1:0];
    legal           = jc_legal(code, WIDTH);
  end

endmodule

// File: rtl/johnson_decode.sv
// Johnson bus receiver: decode, step check and SEARCH/LOCKED tracking.
// Optional JC_ERR_COUNT_EN adds a saturating err_cnt output.
module johnson_decode
  import jc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2,
  localparam int IW      = jc_iw(WIDTH)
) (
  input  logic             clk,
  input  logic             r,
  input  logic [0:WIDTH-1] jc_in,
  input  logic             in_valid,
  output logic [IW-1:0]    idx,
  output logic             idx_valid,
  output logic             code_err,
  output logic             step_err,
  output logic             locked
`ifdef JC_ERR_COUNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  logic          legal;
  logic [IW-1:0] chk_idx;
  logic [IW-1:0] nxt_idx;
  logic          good_step;
  logic          bad_samp;

  jc_state_e     state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          have_prev_q, have_prev_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          idx_valid_q, idx_valid_d;
  logic          code_err_q, code_err_d;
  logic          step_err_q, step_err_d;

  johnson_code_chk #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_chk (
    .jc_in (jc_in),
    .legal (legal),
    .idx   (chk_idx)
  );

  // idx_q doubles as the previous index since it holds on illegal codes
  assign nxt_idx = (idx_q == IW'(2 * WIDTH - 1)) ? '0 : idx_q + 1'b1;
  assign good_step = legal && have_prev_q && (chk_idx == nxt_idx);
  assign bad_samp  = !legal || (have_prev_q && (chk_idx != nxt_idx));

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    miss_d      = miss_q;
    have_prev_d = have_prev_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    code_err_d  = 1'b0;
    step_err_d  = 1'b0;
    if (in_valid) begin
      code_err_d  = !legal;
      idx_valid_d = legal;
      step_err_d  = legal && bad_samp;
      if (legal) idx_d = chk_idx;
      unique case (state_q)
        JC_SEARCH: begin
          if (legal) have_prev_d = 1'b1;
          if (bad_samp) begin
            good_d = '0;
          end else if (good_step) begin
            if (good_q == GW'(LOCK_CNT - 1)) begin
              state_d = JC_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        JC_LOCKED: begin
          if (bad_samp) begin
            if (miss_q == MW'(MISS_MAX - 1)) begin
              state_d     = JC_SEARCH;
              miss_d      = '0;
              good_d      = '0;
              have_prev_d = 1'b0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else if (good_step) begin
            miss_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= JC_SEARCH;
      good_q      <= '0;
      miss_q      <= '0;
      have_prev_q <= 1'b0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      have_prev_q <= have_prev_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      code_err_q  <= code_err_d;
      step_err_q  <= step_err_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign code_err  = code_err_q;
  assign step_err  = step_err_q;
  assign locked    = (state_q == JC_LOCKED);

`ifdef JC_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((code_err_d || step_err_d) && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (r) err_cnt_q <= '0;
    else   err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_johnson_decode.sv
// Directed self-checking bench for johnson_decode (WIDTH=8).
// Build with JC_ERR_COUNT_EN to also exercise err_cnt.
module tb_johnson_decode;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         r;
  logic [0:W-1] jc_in;
  logic         in_valid;
  logic [3:0]   idx;
  logic         idx_valid;
  logic         code_err;
  logic         step_err;
  logic         locked;
`ifdef JC_ERR_COUNT_EN
  logic [15:0]  err_cnt;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  johnson_decode #(
    .WIDTH    (W),
    .LOCK_CNT (4),
    .MISS_MAX (2)
  ) dut (
    .clk       (clk),
    .r         (r),
    .jc_in     (jc_in),
    .in_valid  (in_valid),
    .idx       (idx),
    .idx_valid (idx_valid),
    .code_err  (code_err),
    .step_err  (step_err),
    .locked    (locked)
`ifdef JC_ERR_COUNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [0:W-1] jc_of(input int i);
    logic [0:W-1] c;
    for (int b = 0; b < W; b++)
      c[b] = (i <= W) ? (b < i) : (b >= i - W);
    return c;
  endfunction

  task automatic cyc(input logic rr, input logic v, input logic [0:W-1] c);
    @(negedge clk);
    r        = rr;
    in_valid = v;
    jc_in    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int e_idx,
                            input logic e_iv, input logic e_ce,
                            input logic e_se, input logic e_lk);
    chk({tag, ".idx"}, 32'(idx), 32'(e_idx));
    chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(e_iv));
    chk({tag, ".code_err"}, 32'(code_err), 32'(e_ce));
    chk({tag, ".step_err"}, 32'(step_err), 32'(e_se));
    chk({tag, ".locked"}, 32'(locked), 32'(e_lk));
  endtask

  initial begin
    r        = 1'b1;
    in_valid = 1'b0;
    jc_in    = '0;

    cyc(1'b1, 1'b1, jc_of(3));
    cyc(1'b1, 1'b1, jc_of(3));
    expect_out("reset", 0, 0, 0, 0, 0);
`ifdef JC_ERR_COUNT_EN
    chk("reset.err_cnt", 32'(err_cnt), 0);
`endif

    for (int i = 0; i <= 16; i++) begin
      cyc(1'b0, 1'b1, jc_of(i % 16));
      expect_out($sformatf("seq%0d", i), i % 16, 1, 0, 0, i >= 4);
    end

    cyc(1'b0, 1'b1, 8'b10100000);
    expect_out("illegal1", 0, 0, 1, 0, 1);
    cyc(1'b0, 1'b1, 8'b10100000);
    expect_out("illegal2", 0, 0, 1, 0, 0);

    for (int i = 0; i <= 4; i++) begin
      cyc(1'b0, 1'b1, jc_of(i));
      expect_out($sformatf("relock%0d", i), i, 1, 0, 0, i == 4);
    end
    for (int i = 5; i <= 19; i++) cyc(1'b0, 1'b1, jc_of(i % 16));
    chk("preskip.idx", 32'(idx), 3);

    cyc(1'b0, 1'b1, 8'b11111000);
    expect_out("skip", 5, 1, 0, 1, 1);
    cyc(1'b0, 1'b1, 8'b11111100);
    expect_out("after_skip", 6, 1, 0, 0, 1);
    cyc(1'b0, 1'b1, 8'b11011000);
    expect_out("miss_cleared", 6, 0, 1, 0, 1);
    cyc(1'b0, 1'b1, jc_of(7));
    expect_out("step7", 7, 1, 0, 0, 1);

    cyc(1'b0, 1'b0, 8'b10100000);
    expect_out("hold1", 7, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, jc_of(12));
    expect_out("hold2", 7, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, jc_of(2));
    expect_out("hold3", 7, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, jc_of(8));
    expect_out("resume", 8, 1, 0, 0, 1);
    cyc(1'b0, 1'b1, jc_of(8));
    expect_out("repeat", 8, 1, 0, 1, 1);
    cyc(1'b0, 1'b1, jc_of(9));
    expect_out("step9", 9, 1, 0, 0, 1);
`ifdef JC_ERR_COUNT_EN
    chk("run.err_cnt", 32'(err_cnt), 5);
`endif

    cyc(1'b1, 1'b1, jc_of(10));
    expect_out("mid_reset", 0, 0, 0, 0, 0);
`ifdef JC_ERR_COUNT_EN
    chk("mid_reset.err_cnt", 32'(err_cnt), 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'b10100000);
    chk("three_err.err_cnt", 32'(err_cnt), 3);
    cyc(1'b1, 1'b0, '0);
    chk("clear.err_cnt", 32'(err_cnt), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
